jpeg_mcu_buffer: RTL

Parametrised double-buffered (ping-pong) MCU store between the IDCT output and the colour converter. It accepts 8x8 blocks in natural (de-zigzagged) raster order for one MCU and selects the block layout at run time: 4:4:4, 4:2:2, 4:2:0 or grayscale. It streams the finished MCU out in pixel raster order with Y/Cb/Cr aligned, and upsamples chroma by replication. Valid/ready handshakes on both sides let the IDCT fill one bank while the converter drains the other.

---
 rtl/jpeg_mcu_buffer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/jpeg_mcu_buffer.sv
// Ping-pong MCU store between the IDCT and the colour converter.
// One bank fills in block order while the other drains in pixel raster order.
module jpeg_mcu_buffer #(
   parameter int              DW          = 9,
   parameter logic [DW-1:0]   CHROMA_FILL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    in_mode,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_y,
   output logic [DW-1:0] out_cb,
   output logic [DW-1:0] out_cr,
   output logic [3:0]    out_px,
   output logic [3:0]    out_py,
   output logic          out_last,
   output logic [1:0]    bank_full
);

   localparam logic [1:0] M444  = 2'd0;
   localparam logic [1:0] M422  = 2'd1;
   localparam logic [1:0] M420  = 2'd2;
   localparam logic [1:0] MGRAY = 2'd3;

   // Y is kept as a 16x16 image per bank, chroma as 8x8 per bank.
   logic [DW-1:0] mem_y  [512];
   logic [DW-1:0] mem_cb [128];
   logic [DW-1:0] mem_cr [128];

   logic [1:0] full;
   logic [1:0] bank_mode [2];
   logic       en;
   logic       wp;
   logic       rp;
   logic       ld_bank;
   logic [5:0] smp;
   logic [2:0] blk;
   logic [3:0] ld_x;
   logic [3:0] ld_y;

   function automatic logic [2:0] luma_blocks(input logic [1:0] m);
      case (m)
         M422:    return 3'd2;
         M420:    return 3'd4;
         default: return 3'd1;
      endcase
   endfunction

   logic       wr_go;
   logic       wr_first;
   logic [1:0] wr_mode;
   logic [2:0] wr_nluma;
   logic [2:0] wr_blk_last;
   logic       wr_y;
   logic       wr_cb;
   logic       wr_cr;
   logic       mcu_done;

   assign in_ready    = en && !full[wp];
   assign wr_go       = in_valid && in_ready;
   assign wr_first    = (smp == 6'd0) && (blk == 3'd0);
   // The very first sample decodes with the live mode; it is latched on that same edge.
   assign wr_mode     = wr_first ? in_mode : bank_mode[wp];
   assign wr_nluma    = luma_blocks(wr_mode);
   assign wr_blk_last = (wr_mode == MGRAY) ? 3'd0 : wr_nluma + 3'd1;
   assign wr_y        = blk < wr_nluma;
   assign wr_cb       = !wr_y && (blk == wr_nluma);
   assign wr_cr       = !wr_y && !wr_cb;
   assign mcu_done    = wr_go && (smp == 6'd63) && (blk == wr_blk_last);

   logic [1:0] rd_mode;
   logic [3:0] x_max;
   logic [3:0] y_max;
   logic [5:0] c_idx;
   logic       load;
   logic       ld_last;
   logic       release_bank;

   assign rd_mode = bank_mode[ld_bank];
   assign x_max   = (rd_mode == M422 || rd_mode == M420) ? 4'd15 : 4'd7;
   assign y_max   = (rd_mode == M420) ? 4'd15 : 4'd7;
   assign ld_last = (ld_x == x_max) && (ld_y == y_max);

   always_comb begin
      c_idx = {ld_y[2:0], ld_x[2:0]};
      case (rd_mode)
         M422:    c_idx = {ld_y[2:0], ld_x[3:1]};
         M420:    c_idx = {ld_y[3:1], ld_x[3:1]};
         default: c_idx = {ld_y[2:0], ld_x[2:0]};
      endcase
   end

   // ld_bank runs one pixel ahead of rp, so the next MCU loads while the last pixel waits.
   assign load         = full[ld_bank] && (!out_valid || out_ready);
   assign release_bank = out_valid && out_ready && out_last;
   assign bank_full    = full;

   always_ff @(posedge clk) begin
      if (rst && wr_go) begin
         if (wr_y)  mem_y[{wp, blk[1], smp[5:3], blk[0], smp[2:0]}] <= in_data;
         if (wr_cb) mem_cb[{wp, smp}] <= in_data;
         if (wr_cr) mem_cr[{wp, smp}] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         en           <= 1'b0;
         full         <= 2'b00;
         bank_mode[0] <= M444;
         bank_mode[1] <= M444;
         wp           <= 1'b0;
         rp           <= 1'b0;
         ld_bank      <= 1'b0;
         smp          <= 6'd0;
         blk          <= 3'd0;
         ld_x         <= 4'd0;
         ld_y         <= 4'd0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         out_y        <= '0;
         out_cb       <= '0;
         out_cr       <= '0;
         out_px       <= 4'd0;
         out_py       <= 4'd0;
      end else begin
         en <= 1'b1;

         if (wr_go) begin
            if (wr_first) bank_mode[wp] <= in_mode;
            if (smp == 6'd63) begin
               smp <= 6'd0;
               if (blk == wr_blk_last) begin
                  blk <= 3'd0;
                  wp  <= ~wp;
               end else begin
                  blk <= blk + 3'd1;
               end
            end else begin
               smp <= smp + 6'd1;
            end
         end

         full <= (full | (mcu_done ? (2'b01 << wp) : 2'b00))
                 & ~(release_bank ? (2'b01 << rp) : 2'b00);
         if (release_bank) rp <= ~rp;

         if (load) begin
            out_valid <= 1'b1;
            out_y     <= mem_y[{ld_bank, ld_y, ld_x}];
            out_cb    <= (rd_mode == MGRAY) ? CHROMA_FILL : mem_cb[{ld_bank, c_idx}];
            out_cr    <= (rd_mode == MGRAY) ? CHROMA_FILL : mem_cr[{ld_bank, c_idx}];
            out_px    <= ld_x;
            out_py    <= ld_y;
            out_last  <= ld_last;
            if (ld_last) begin
               ld_x    <= 4'd0;
               ld_y    <= 4'd0;
               ld_bank <= ~ld_bank;
            end else if (ld_x == x_max) begin
               ld_x <= 4'd0;
               ld_y <= ld_y + 4'd1;
            end else begin
               ld_x <= ld_x + 4'd1;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule
